mem_access_arbiter: RTL and testbench

Sequences every access to MAIN_MEMORY and shares it between two requesters: the instruction-fetch path (requester 0) and the load/store path of the control unit (requester 1). It arbitrates round-robin, drives the memory RD/WR/address/data lines, waits for ACK with a timeout, and latches read data. It also produces the select that steers memory data onto bus C.

---
 rtl/mem_access_arbiter_pkg.sv | 21 ++
 rtl/mem_access_arbiter_rr_arbiter_2.sv | 37 +++
 rtl/mem_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the main-memory access arbiter: FSM encoding,
// requester indices and the default ACK timeout.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } arbState_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    function automatic logic [1:0] oneHot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational winner selection plus the
// last-owner pointer, which is updated only when ptrEn is asserted.
module rr_arbiter_2
    import mem_access_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       ptrEn,
    input  logic       ptrOwner,
    output logic       winner,
    output logic       anyReq
);

    logic lastOwner;

    // Starting with the data path as "last owner" makes fetch win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastOwner <= REQ_DATA;
        end else if (ptrEn) begin
            lastOwner <= ptrOwner;
        end
    end

    always_comb begin
        anyReq = |req;
        winner = REQ_FETCH;
        case (req)
            2'b01:   winner = REQ_FETCH;
            2'b10:   winner = REQ_DATA;
            2'b11:   winner = ~lastOwner;
            default: winner = REQ_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares MAIN_MEMORY between instruction fetch and load/store: round-robin
// grant, registered memory strobes, ACK timeout and latched read data.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = 5
) (
    input  logic                     MEM_ACCESS_ARBITER_CLOCK_50,
    input  logic                     MEM_ACCESS_ARBITER_RESET_InHigh,
    input  logic [1:0]               req_InBUS,
    input  logic [1:0]               we_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] addr0_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] addr1_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] wdata0_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] wdata1_InBUS,
    output logic [1:0]               grant_OutBUS,
    output logic [1:0]               done_OutBUS,
    output logic [1:0]               err_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] rdata_OutBUS,
    output logic                     busc_sel_Out,
    output logic                     MEM_RD_Out,
    output logic                     MEM_WR_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_ADDR_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_WDATA_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_RDATA_InBUS,
    input  logic                     MEM_ACK_In
);

    localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic clk;
    logic rst;
    assign clk = MEM_ACCESS_ARBITER_CLOCK_50;
    assign rst = MEM_ACCESS_ARBITER_RESET_InHigh;

    arbState_t state;
    arbState_t stateNext;

    logic [TIMEOUT_WIDTH-1:0] count;
    logic                     owner;
    logic                     winner;
    logic                     anyReq;
    logic                     timeoutHit;
    logic                     ptrEn;

    logic [1:0]               grantQ;
    logic [1:0]               doneQ;
    logic [1:0]               errQ;
    logic [DATAWIDTH_BUS-1:0] rdataQ;
    logic                     buscSelQ;
    logic                     memRdQ;
    logic                     memWrQ;
    logic [DATAWIDTH_BUS-1:0] memAddrQ;
    logic [DATAWIDTH_BUS-1:0] memWdataQ;

    assign timeoutHit = (count == LAST_COUNT);
    assign ptrEn      = (state == DONE) || (state == ERR);

    rr_arbiter_2 uArb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_InBUS),
        .ptrEn    (ptrEn),
        .ptrOwner (owner),
        .winner   (winner),
        .anyReq   (anyReq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // An ACK arriving on the final timeout cycle takes priority over the abort.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = ACCESS;
            ACCESS: begin
                if (MEM_ACK_In) begin
                    stateNext = DONE;
                end else if (timeoutHit) begin
                    stateNext = ERR;
                end
            end
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            owner     <= REQ_FETCH;
            grantQ    <= '0;
            doneQ     <= '0;
            errQ      <= '0;
            rdataQ    <= '0;
            buscSelQ  <= 1'b0;
            memRdQ    <= 1'b0;
            memWrQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner     <= winner;
                        grantQ    <= oneHot(winner);
                        memAddrQ  <= winner ? addr1_InBUS : addr0_InBUS;
                        memWdataQ <= winner ? wdata1_InBUS : wdata0_InBUS;
                        memRdQ    <= ~we_InBUS[winner];
                        memWrQ    <= we_InBUS[winner];
                        count     <= '0;
                    end
                end
                ACCESS: begin
                    if (MEM_ACK_In) begin
                        memRdQ <= 1'b0;
                        memWrQ <= 1'b0;
                        doneQ  <= oneHot(owner);
                        if (memRdQ) begin
                            rdataQ   <= MEM_RDATA_InBUS;
                            buscSelQ <= 1'b1;
                        end
                    end else if (timeoutHit) begin
                        memRdQ <= 1'b0;
                        memWrQ <= 1'b0;
                        errQ   <= oneHot(owner);
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE, ERR: begin
                    doneQ    <= '0;
                    errQ     <= '0;
                    buscSelQ <= 1'b0;
                    grantQ   <= '0;
                end
                default: begin
                    grantQ <= '0;
                end
            endcase
        end
    end

    assign grant_OutBUS     = grantQ;
    assign done_OutBUS      = doneQ;
    assign err_OutBUS       = errQ;
    assign rdata_OutBUS     = rdataQ;
    assign busc_sel_Out     = buscSelQ;
    assign MEM_RD_Out       = memRdQ;
    assign MEM_WR_Out       = memWrQ;
    assign MEM_ADDR_OutBUS  = memAddrQ;
    assign MEM_WDATA_OutBUS = memWdataQ;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter: vector table of single accesses plus
// hand sequences for tie alternation, async reset and stray ACK.
module tb_mem_access_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req = '0;
    logic [1:0]    we = '0;
    logic [DW-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0]    grant, done, err;
    logic [DW-1:0] rdata;
    logic          buscSel, memRd, memWr;
    logic [DW-1:0] memAddr, memWdata;
    logic [DW-1:0] memRdata = '0;
    logic          memAck = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    expGrant;
        logic          expErr;
        logic          expWr;
        logic [DW-1:0] expRdata;
    } sbEntry_t;

    sbEntry_t sb[$];

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic [DW-1:0] a0, a1, w0, w1;
        int            ackAt;
        logic [DW-1:0] memData;
        logic [1:0]    expGrant;
        logic          expErr;
        logic [DW-1:0] expRdata;
    } vec_t;

    vec_t vecs[7];

    mem_access_arbiter #(
        .DATAWIDTH_BUS  (DW),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_WIDTH  (5)
    ) dut (
        .MEM_ACCESS_ARBITER_CLOCK_50     (clk),
        .MEM_ACCESS_ARBITER_RESET_InHigh (rst),
        .req_InBUS        (req),
        .we_InBUS         (we),
        .addr0_InBUS      (addr0),
        .addr1_InBUS      (addr1),
        .wdata0_InBUS     (wdata0),
        .wdata1_InBUS     (wdata1),
        .grant_OutBUS     (grant),
        .done_OutBUS      (done),
        .err_OutBUS       (err),
        .rdata_OutBUS     (rdata),
        .busc_sel_Out     (buscSel),
        .MEM_RD_Out       (memRd),
        .MEM_WR_Out       (memWr),
        .MEM_ADDR_OutBUS  (memAddr),
        .MEM_WDATA_OutBUS (memWdata),
        .MEM_RDATA_InBUS  (memRdata),
        .MEM_ACK_In       (memAck)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives one request from IDLE (called at a falling edge) and follows it to completion.
    task automatic doAccess(input string nm, input logic [1:0] reqV, input logic [1:0] weV,
                            input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                            input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input int ackAt, input logic [DW-1:0] memData,
                            input logic [1:0] expGrant, input logic expErr,
                            input logic [DW-1:0] expRdata, input logic dropReq);
        sbEntry_t e;
        logic     expWr;
        int       k;
        bit       finished;
        req = reqV; we = weV; addr0 = a0; addr1 = a1; wdata0 = w0; wdata1 = w1;
        expWr = expGrant[1] ? weV[1] : weV[0];
        e.expGrant = expGrant; e.expErr = expErr; e.expWr = expWr; e.expRdata = expRdata;
        sb.push_back(e);
        @(negedge clk);
        chk({nm, ".grant"}, 32'(grant), 32'(expGrant));
        chk({nm, ".addr"}, memAddr, expGrant[1] ? a1 : a0);
        chk({nm, ".wdata"}, memWdata, expGrant[1] ? w1 : w0);
        chk({nm, ".rd"}, 32'(memRd), 32'(!expWr));
        chk({nm, ".wr"}, 32'(memWr), 32'(expWr));
        k = 1;
        finished = 0;
        while (!finished && k <= 40) begin
            if (k == ackAt) begin
                memAck = 1'b1;
                memRdata = memData;
            end
            @(negedge clk);
            memAck = 1'b0;
            if (done != 2'b00 || err != 2'b00 || (!memRd && !memWr)) begin
                finished = 1;
            end else begin
                chk({nm, ".strobeHold"}, {30'd0, memRd, memWr}, {30'd0, !expWr, expWr});
                chk({nm, ".buscIdle"}, 32'(buscSel), 32'd0);
                k++;
            end
        end
        if (!finished) begin
            chk({nm, ".completionBound"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk({nm, ".sbUnderflow"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, ".strobeCycles"}, 32'(k), 32'(e.expErr ? TMO : ackAt));
            chk({nm, ".done"}, 32'(done), e.expErr ? 32'd0 : 32'(e.expGrant));
            chk({nm, ".err"}, 32'(err), e.expErr ? 32'(e.expGrant) : 32'd0);
            chk({nm, ".grantHold"}, 32'(grant), 32'(e.expGrant));
            chk({nm, ".rdata"}, rdata, e.expRdata);
            chk({nm, ".buscSel"}, 32'(buscSel), 32'(!e.expErr && !e.expWr));
            chk({nm, ".strobeOff"}, {30'd0, memRd, memWr}, 32'd0);
        end
        if (dropReq) req = 2'b00;
        @(negedge clk);
        chk({nm, ".idle"}, {24'd0, grant, done, err, memRd, memWr}, 32'd0);
        chk({nm, ".idleBusc"}, 32'(buscSel), 32'd0);
        chk({nm, ".rdataHeld"}, rdata, expRdata);
    endtask

    initial begin
        // req, we, a0, a1, w0, w1, ackAt, memData, expGrant, expErr, expRdata
        vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 2, 32'hDEADBEEF, 2'b01, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h12345678, 3, 32'hBAD0BAD0, 2'b10, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{2'b01, 2'b01, 32'h44, 32'h0, 32'hA5A5A5A5, 32'h0, 1, 32'h77777777, 2'b01, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{2'b10, 2'b00, 32'h0, 32'h80, 32'h0, 32'h0, 1, 32'h0BADF00D, 2'b10, 1'b0, 32'h0BADF00D};
        vecs[4] = '{2'b01, 2'b00, 32'h90, 32'h0, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 2'b01, 1'b1, 32'h0BADF00D};
        vecs[5] = '{2'b10, 2'b00, 32'h0, 32'hA0, 32'h0, 32'h0, 16, 32'h13579BDF, 2'b10, 1'b0, 32'h13579BDF};
        vecs[6] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 2, 32'h11111111, 2'b01, 1'b0, 32'h11111111};

        rst = 1'b1;
        #1;
        chk("reset.outs", {24'd0, grant, done, err, memRd, memWr}, 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        chk("reset.addr", memAddr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Held tie from reset: fetch, data, fetch with an idle cycle between each.
        doAccess("tie0", 2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0, 1, 32'h0A0A0001, 2'b01, 1'b0, 32'h0A0A0001, 1'b0);
        doAccess("tie1", 2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0, 2, 32'h0B0B0002, 2'b10, 1'b0, 32'h0B0B0002, 1'b0);
        doAccess("tie2", 2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0, 1, 32'h0C0C0003, 2'b01, 1'b0, 32'h0C0C0003, 1'b1);

        for (int i = 0; i < 7; i++) begin
            doAccess($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1,
                     vecs[i].w0, vecs[i].w1, vecs[i].ackAt, vecs[i].memData,
                     vecs[i].expGrant, vecs[i].expErr, vecs[i].expRdata, 1'b1);
        end

        // Asynchronous reset in the middle of an access.
        req = 2'b01; we = 2'b00; addr0 = 32'h55;
        @(negedge clk);
        chk("midReset.strobeBefore", 32'(memRd), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midReset.outs", {24'd0, grant, done, err, memRd, memWr}, 32'd0);
        chk("midReset.rdata", rdata, 32'd0);
        chk("midReset.busc", 32'(buscSel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doAccess("afterReset", 2'b11, 2'b00, 32'h60, 32'h70, 32'h0, 32'h0, 1, 32'h2468ACE0, 2'b01, 1'b0, 32'h2468ACE0, 1'b1);

        // Stray ACK with nothing requested.
        req = 2'b00;
        memAck = 1'b1;
        memRdata = 32'hCAFECAFE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("strayAck%0d", i), {24'd0, grant, done, err, memRd, memWr}, 32'd0);
            chk($sformatf("strayAckRdata%0d", i), rdata, 32'h2468ACE0);
        end
        memAck = 1'b0;
        doAccess("afterStray", 2'b10, 2'b00, 32'h0, 32'h88, 32'h0, 32'h0, 2, 32'h99990000, 2'b10, 1'b0, 32'h99990000, 1'b1);

        chk("sbEmpty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
